compare_serial: RTL
===================

COMPARE_SERIAL -- requirements
Module: compare_serial

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits.
REQ-002 Parameter CHUNK, default 16, bits compared per cycle; WIDTH % CHUNK != 0 or CHUNK < 1 SHALL be an elaboration error.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request a compare; accepted only in IDLE.
REQ-006 Port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 Port A  input  WIDTH  first operand; sampled with start.
REQ-008 Port B  input  WIDTH  second operand; sampled with start.
REQ-009 Port busy  output  1  high whenever state != IDLE.
REQ-010 Port done  output  1  one-cycle pulse marking a new result.
REQ-011 Port LT  output  1  registered result, A < B.
REQ-012 Port EQ  output  1  registered result, A == B.
REQ-013 Port GT  output  1  registered result, A > B.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 SHALL latch A, B and signed_mode, set chunk index to NCHUNK-1 (NCHUNK = WIDTH/CHUNK), and go to RUN.
REQ-016 Each RUN cycle SHALL compare exactly one latched chunk pair, MSB chunk first, index decrementing.
REQ-017 In signed mode, only the MSB chunk SHALL be compared as signed; all lower chunks SHALL be compared unsigned.
REQ-018 An unequal chunk SHALL register LT or GT from that chunk and go to DONE immediately (early termination).
REQ-019 An equal chunk at index 0 SHALL register EQ=1 and go to DONE.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 Latency: start sampled in cycle 0, m chunks examined (1..NCHUNK), then done=1 in cycle m+1.
REQ-022 Back-to-back throughput: next start accepted no earlier than cycle m+2.
REQ-023 start SHALL be ignored in RUN and DONE, with no queuing.
REQ-024 Changes on A, B or signed_mode after acceptance SHALL NOT affect the result in progress.
REQ-025 LT/EQ/GT SHALL update only on entry to DONE and hold until the next DONE.
REQ-026 After the first completion, exactly one of LT/EQ/GT SHALL be high.
REQ-027 CHUNK == WIDTH SHALL be legal: single RUN cycle, done in cycle 2.

Reset
REQ-028 rst=1 SHALL force state IDLE, busy=0, done=0 and LT=EQ=GT=0 at the next edge.
REQ-029 Reset mid-RUN or in DONE SHALL abandon the operation with no done pulse.
REQ-030 rst SHALL take priority over a simultaneous start.
REQ-031 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-032 Shared package compare_pkg SHALL hold the state enum (IDLE/RUN/DONE) and a function computing NCHUNK and the chunk-index width ($clog2, minimum 1).
REQ-033 One combinational sub-module, compare_chunk, SHALL be used.
REQ-034 compare_chunk SHALL be parameterised by CHUNK, take inputs a, b and is_signed, and produce outputs lt and gt.
REQ-035 The top level SHALL contain only the FSM, operand registers, index counter and result registers.

Verification (WIDTH=64, CHUNK=16 unless stated)
REQ-036 Equal operands: A=B=0x0123456789ABCDEF, unsigned -> done in cycle 5, EQ=1, LT=GT=0.
REQ-037 MSB chunk differs: A=0xFFFF000000000000, B=0x0001000000000000; unsigned -> GT=1, done in cycle 2; signed -> LT=1, done in cycle 2.
REQ-038 Only lowest chunk differs: A=0x...0001, B=0x...0002 (upper chunks equal) -> LT=1, done in cycle 5; the same pair in signed mode -> LT=1.
REQ-039 start held high throughout plus operand changes mid-RUN -> exactly one done per accepted start, result from the latched operands only, next acceptance in the cycle after DONE.
REQ-040 rst pulsed in cycle 2 of a 4-chunk compare -> busy=0, LT=EQ=GT=0, no done; the following start completes correctly.
REQ-041 Randomised, 10k pairs, both modes, CHUNK in {16, 64, 8}: result matches a direct signed/unsigned <, ==, > of A and B, and done cycle == index of the first differing chunk from MSB + 1.

Source files
------------

// File: rtl/compare_pkg.sv
// Shared types and sizing helpers for the chunk-serial magnitude comparator.
package compare_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        if (chunk < 1) begin
            return 1;
        end
        return width / chunk;
    endfunction

    // Index counter width, never narrower than one bit.
    function automatic int calc_idx_w(input int width, input int chunk);
        int n;
        n = calc_nchunk(width, chunk);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/compare_chunk.sv
// Combinational less-than / greater-than of one chunk pair, signed or unsigned.
module compare_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed,
    output logic             lt,
    output logic             gt
);

    logic signed [CHUNK-1:0] a_s;
    logic signed [CHUNK-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        if (is_signed) begin
            lt = (a_s < b_s);
            gt = (a_s > b_s);
        end else begin
            lt = (a < b);
            gt = (a > b);
        end
    end

endmodule

// File: rtl/compare_serial.sv
// Multi-cycle comparator: walks latched operands one chunk per cycle, MSB chunk
// first, and stops at the first unequal chunk.
module compare_serial
    import compare_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(WIDTH, CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0) begin : g_bad_chunk
        $error("compare_serial: CHUNK must be >= 1 and divide WIDTH");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic             chunk_signed;
    logic             chunk_lt;
    logic             chunk_gt;
    logic             accept;

    assign accept = (state == IDLE) && start;

    // Operands shift left each RUN cycle so the chunk under test is always on top.
    if (NCHUNK > 1) begin : g_shift
        assign a_shift = {a_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
        assign b_shift = {b_q[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_no_shift
        assign a_shift = a_q;
        assign b_shift = b_q;
    end

    // Only the sign-carrying MSB chunk is compared as two's complement.
    assign chunk_signed = signed_q && (idx == LAST_IDX);

    compare_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_q[WIDTH-1 -: CHUNK]),
        .b        (b_q[WIDTH-1 -: CHUNK]),
        .is_signed(chunk_signed),
        .lt       (chunk_lt),
        .gt       (chunk_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (chunk_lt || chunk_gt || idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q      <= A;
            b_q      <= B;
            signed_q <= signed_mode;
        end else if (state == RUN) begin
            a_q <= a_shift;
            b_q <= b_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= LAST_IDX;
        end else if (state == RUN) begin
            idx <= idx - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LT <= 1'b0;
            EQ <= 1'b0;
            GT <= 1'b0;
        end else if (state == RUN && state_nxt == DONE) begin
            LT <= chunk_lt;
            GT <= chunk_gt;
            EQ <= !(chunk_lt || chunk_gt);
        end
    end

endmodule
